// File: rtl/rvv_backend_mul_rs_fifo.sv
// -----------------------------------------------------------------------------
// rvv_backend_mul_rs_fifo
//
// Reservation-station FIFO for the vector multiply unit. It accepts up to two
// entries per cycle and presents the two oldest entries to the consumer, which
// may retire up to two entries per cycle. Storage is a DEPTH-entry circular
// buffer. The memory is not reset; only the pointers, the occupancy count and
// the error flag are.
//
// Build option:
//   RVV_MUL_RS_FIFO_CHECK_EN - when defined, illegal push/pop bits are ignored
//                              and a sticky fifo_err is raised, held until rst.
//                              When undefined, requests are taken as given and
//                              fifo_err is tied to 0.
//
// Parameters:
//   DEPTH  - number of entries (power of two, >= 4)
//   DWIDTH - width of one packed MUL_RS_t entry
//
// Ports:
//   clk                 - clock, all state updates on the rising edge
//   rst                 - synchronous active-high reset
//   trap_flush_rvv      - synchronous flush; discards this cycle's push/pop
//   push[1:0]           - push[0] writes lane 0, push[1] writes lane 1
//   data_in             - two entries, lane i at [i*DWIDTH +: DWIDTH]
//   fifo_full           - count == DEPTH
//   fifo_1left_to_full  - count == DEPTH-1
//   uop_data            - lane 0 = oldest entry, lane 1 = second oldest
//   fifo_empty          - count == 0
//   fifo_1left_to_empty - count == 1
//   pop[1:0]            - pop[0] removes oldest, pop[1] also the second oldest
//   fifo_err            - sticky illegal-access flag
// -----------------------------------------------------------------------------
module rvv_backend_mul_rs_fifo #(
   parameter int DEPTH  = 8,
   parameter int DWIDTH = 512
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                trap_flush_rvv,
   input  logic [1:0]          push,
   input  logic [2*DWIDTH-1:0] data_in,
   output logic                fifo_full,
   output logic                fifo_1left_to_full,
   output logic [2*DWIDTH-1:0] uop_data,
   output logic                fifo_empty,
   output logic                fifo_1left_to_empty,
   input  logic [1:0]          pop,
   output logic                fifo_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_FULL1 = CW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_ROOM2 = CW'(DEPTH - 2);
   localparam logic [CW-1:0] CNT_TWO   = CW'(2);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO  = '0;

   logic [DWIDTH-1:0] mem [DEPTH];

   logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0] count_reg, count_next;
   logic [AW-1:0] wr_ptr_p1;
   logic [1:0]    push_ok;
   logic [1:0]    pop_ok;

   // Flags come from the registered count only.
   assign fifo_full           = (count_reg == CNT_FULL);
   assign fifo_1left_to_full  = (count_reg == CNT_FULL1);
   assign fifo_empty          = (count_reg == CNT_ZERO);
   assign fifo_1left_to_empty = (count_reg == CNT_ONE);

   assign wr_ptr_p1 = wr_ptr_reg + AW'(1);

`ifdef RVV_MUL_RS_FIFO_CHECK_EN
   logic err_reg, err_next;
   logic illegal;

   // Legality is judged on the current count; a same-cycle pop does not make
   // room for a push. A rejected bit also rejects every bit above it.
   always_comb begin
      push_ok    = 2'b00;
      pop_ok     = 2'b00;
      push_ok[0] = push[0] & ~fifo_full;
      push_ok[1] = push_ok[0] & push[1] & (count_reg <= CNT_ROOM2);
      pop_ok[0]  = pop[0] & ~fifo_empty;
      pop_ok[1]  = pop_ok[0] & pop[1] & (count_reg >= CNT_TWO);
      illegal    = (|(push & ~push_ok)) | (|(pop & ~pop_ok));
      // A flush discards the cycle's requests, so they are not judged.
      err_next   = err_reg | (illegal & ~trap_flush_rvv);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_reg <= 1'b0;
      end else begin
         err_reg <= err_next;
      end
   end

   assign fifo_err = err_reg;
`else
   // Producer and consumer guarantee legal requests.
   assign push_ok  = push;
   assign pop_ok   = pop;
   assign fifo_err = 1'b0;
`endif

   always_comb begin
      wr_ptr_next = wr_ptr_reg + AW'(push_ok[0]) + AW'(push_ok[1]);
      rd_ptr_next = rd_ptr_reg + AW'(pop_ok[0]) + AW'(pop_ok[1]);
      count_next  = count_reg + CW'(push_ok[0]) + CW'(push_ok[1])
                    - CW'(pop_ok[0]) - CW'(pop_ok[1]);
   end

   always_ff @(posedge clk) begin
      if (rst || trap_flush_rvv) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

   // Entry storage: no reset, writes suppressed while reset or flush is active.
   always_ff @(posedge clk) begin
      if (!rst && !trap_flush_rvv) begin
         if (push_ok[0]) mem[wr_ptr_reg] <= data_in[0 +: DWIDTH];
         if (push_ok[1]) mem[wr_ptr_p1]  <= data_in[DWIDTH +: DWIDTH];
      end
   end

   // Read lanes straight from registered state, so a pushed entry appears one
   // cycle after its push and never bypasses.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_rd_lane
         logic [AW-1:0] rd_idx;
         assign rd_idx = rd_ptr_reg + AW'(gi);
         assign uop_data[gi*DWIDTH +: DWIDTH] = mem[rd_idx];
      end
   endgenerate

endmodule

// File: tb/tb_rvv_backend_mul_rs_fifo.sv
module tb_rvv_backend_mul_rs_fifo;

   localparam int DEPTH = 8;
   localparam int DW    = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            trap_flush_rvv;
   logic [1:0]      push;
   logic [2*DW-1:0] data_in;
   logic            fifo_full;
   logic            fifo_1left_to_full;
   logic [2*DW-1:0] uop_data;
   logic            fifo_empty;
   logic            fifo_1left_to_empty;
   logic [1:0]      pop;
   logic            fifo_err;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: plain queue of entries plus expected error flag.
   logic [DW-1:0] q[$];
   logic          exp_err = 1'b0;

   rvv_backend_mul_rs_fifo #(.DEPTH(DEPTH), .DWIDTH(DW)) dut (
      .clk                (clk),
      .rst                (rst),
      .trap_flush_rvv     (trap_flush_rvv),
      .push               (push),
      .data_in            (data_in),
      .fifo_full          (fifo_full),
      .fifo_1left_to_full (fifo_1left_to_full),
      .uop_data           (uop_data),
      .fifo_empty         (fifo_empty),
      .fifo_1left_to_empty(fifo_1left_to_empty),
      .pop                (pop),
      .fifo_err           (fifo_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   wire [3:0]    dut_flags = {fifo_full, fifo_1left_to_full, fifo_empty, fifo_1left_to_empty};
   wire [DW-1:0] uop0      = uop_data[0 +: DW];
   wire [DW-1:0] uop1      = uop_data[DW +: DW];

   function automatic logic [3:0] exp_flags();
      int n = q.size();
      return {n == DEPTH, n == DEPTH - 1, n == 0, n == 1};
   endfunction

   // One clock cycle of stimulus; the model is updated at the edge and
   // outputs are sampled 1 time unit later by the caller.
   task automatic cycle(input logic [1:0] p, input logic [1:0] po,
                        input logic f, input logic r);
      logic [DW-1:0] d0, d1;
      int            n;
      logic          pu0, pu1, po0, po1;
      d0 = $urandom;
      d1 = $urandom;
      push = p; pop = po; trap_flush_rvv = f; rst = r;
      data_in = {d1, d0};
      @(posedge clk);
      if (r) begin
         q.delete();
         exp_err = 1'b0;
      end else if (f) begin
         q.delete();
      end else begin
         n = q.size();
`ifdef RVV_MUL_RS_FIFO_CHECK_EN
         pu0 = p[0] && (n < DEPTH);
         pu1 = pu0 && p[1] && (n <= DEPTH - 2);
         po0 = po[0] && (n > 0);
         po1 = po0 && po[1] && (n >= 2);
         if ((p[0] && !pu0) || (p[1] && !pu1) || (po[0] && !po0) || (po[1] && !po1))
            exp_err = 1'b1;
`else
         pu0 = p[0]; pu1 = p[1]; po0 = po[0]; po1 = po[1];
`endif
         if (po0 && q.size() > 0) void'(q.pop_front());
         if (po1 && q.size() > 0) void'(q.pop_front());
         if (pu0) q.push_back(d0);
         if (pu1) q.push_back(d1);
      end
      #1;
      push = 2'b00; pop = 2'b00; trap_flush_rvv = 1'b0; rst = 1'b0;
   endtask

   task automatic test_reset();
      cycle(2'b11, 2'b01, 1'b0, 1'b1);
      cycle(2'b00, 2'b00, 1'b0, 1'b1);
      n_checks++;
      if (dut_flags !== 4'b0010) begin
         n_fail++;
         $display("FAIL reset_flags: got %b want %b", dut_flags, 4'b0010);
      end
      n_checks++;
      if (fifo_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_err: got %b want 0", fifo_err);
      end
      $display("test_reset: flags=%b err=%b", dut_flags, fifo_err);
   endtask

   task automatic test_dual_push();
      cycle(2'b11, 2'b00, 1'b0, 1'b0);
      n_checks++;
      if (uop0 !== q[0] || uop1 !== q[1]) begin
         n_fail++;
         $display("FAIL dual_push_data: got %h/%h want %h/%h", uop0, uop1, q[0], q[1]);
      end
      n_checks++;
      if (dut_flags !== exp_flags() || q.size() != 2) begin
         n_fail++;
         $display("FAIL dual_push_flags: got %b want %b", dut_flags, exp_flags());
      end
      $display("test_dual_push: uop0=%h uop1=%h flags=%b", uop0, uop1, dut_flags);
      cycle(2'b00, 2'b11, 1'b0, 1'b0);
      n_checks++;
      if (dut_flags !== 4'b0010) begin
         n_fail++;
         $display("FAIL dual_pop_empty: got %b want 0010", dut_flags);
      end
   endtask

   task automatic test_full_boundary();
      for (int i = 0; i < 3; i++) cycle(2'b11, 2'b00, 1'b0, 1'b0);
      cycle(2'b01, 2'b00, 1'b0, 1'b0);
      n_checks++;
      if (dut_flags !== 4'b0100) begin
         n_fail++;
         $display("FAIL one_left_to_full: got %b want 0100", dut_flags);
      end
      cycle(2'b01, 2'b00, 1'b0, 1'b0);
      n_checks++;
      if (dut_flags !== 4'b1000) begin
         n_fail++;
         $display("FAIL full: got %b want 1000", dut_flags);
      end
      cycle(2'b00, 2'b11, 1'b0, 1'b0);
      n_checks++;
      if (q.size() != 6 || dut_flags !== exp_flags() || uop0 !== q[0] || uop1 !== q[1]) begin
         n_fail++;
         $display("FAIL full_pop2: got %h/%h flags %b want %h/%h flags %b",
                  uop0, uop1, dut_flags, q[0], q[1], exp_flags());
      end
      $display("test_full_boundary: after pop2 flags=%b uop0=%h", dut_flags, uop0);
      while (q.size() > 0) begin
         n_checks++;
         if (uop0 !== q[0]) begin
            n_fail++;
            $display("FAIL drain_order: got %h want %h", uop0, q[0]);
         end
         cycle(2'b00, 2'b01, 1'b0, 1'b0);
      end
      n_checks++;
      if (dut_flags !== 4'b0010) begin
         n_fail++;
         $display("FAIL drain_empty: got %b want 0010", dut_flags);
      end
   endtask

   task automatic test_wrap();
      cycle(2'b01, 2'b00, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         n_checks++;
         if (uop0 !== q[0] || dut_flags !== exp_flags()) begin
            n_fail++;
            $display("FAIL wrap_%0d: got %h flags %b want %h flags %b",
                     i, uop0, dut_flags, q[0], exp_flags());
         end
         cycle(2'b01, 2'b01, 1'b0, 1'b0);
      end
      $display("test_wrap: 20 push/pop cycles, last uop0=%h", uop0);
      cycle(2'b00, 2'b01, 1'b0, 1'b0);
   endtask

   task automatic test_flush();
      cycle(2'b11, 2'b00, 1'b0, 1'b0);
      cycle(2'b01, 2'b00, 1'b0, 1'b0);
      cycle(2'b11, 2'b01, 1'b1, 1'b0);
      n_checks++;
      if (dut_flags !== 4'b0010 || q.size() != 0) begin
         n_fail++;
         $display("FAIL flush: got %b want 0010", dut_flags);
      end
      cycle(2'b01, 2'b00, 1'b0, 1'b0);
      n_checks++;
      if (uop0 !== q[0] || dut_flags !== 4'b0001) begin
         n_fail++;
         $display("FAIL post_flush: got %h flags %b want %h flags 0001", uop0, dut_flags, q[0]);
      end
      $display("test_flush: flags=%b uop0=%h", dut_flags, uop0);
      cycle(2'b00, 2'b01, 1'b0, 1'b0);
   endtask

   task automatic test_full_push_pop();
      for (int i = 0; i < 4; i++) cycle(2'b11, 2'b00, 1'b0, 1'b0);
      cycle(2'b01, 2'b01, 1'b0, 1'b0);
      n_checks++;
      if (dut_flags !== exp_flags()) begin
         n_fail++;
         $display("FAIL full_push_pop_flags: got %b want %b", dut_flags, exp_flags());
      end
      n_checks++;
      if (fifo_err !== exp_err) begin
         n_fail++;
         $display("FAIL full_push_pop_err: got %b want %b", fifo_err, exp_err);
      end
      $display("test_full_push_pop: flags=%b err=%b", dut_flags, fifo_err);
      while (q.size() > 0) begin
         n_checks++;
         if (uop0 !== q[0]) begin
            n_fail++;
            $display("FAIL full_push_pop_order: got %h want %h", uop0, q[0]);
         end
         cycle(2'b00, 2'b01, 1'b0, 1'b0);
      end
   endtask

`ifdef RVV_MUL_RS_FIFO_CHECK_EN
   task automatic test_check_err();
      cycle(2'b00, 2'b00, 1'b0, 1'b1);
      cycle(2'b01, 2'b00, 1'b0, 1'b0);
      cycle(2'b00, 2'b11, 1'b0, 1'b0);
      n_checks++;
      if (dut_flags !== 4'b0010 || fifo_err !== 1'b1) begin
         n_fail++;
         $display("FAIL bad_pop2: got flags %b err %b want 0010 1", dut_flags, fifo_err);
      end
      cycle(2'b00, 2'b00, 1'b0, 1'b0);
      n_checks++;
      if (fifo_err !== 1'b1) begin
         n_fail++;
         $display("FAIL err_sticky: got %b want 1", fifo_err);
      end
      cycle(2'b00, 2'b00, 1'b0, 1'b1);
      n_checks++;
      if (fifo_err !== 1'b0) begin
         n_fail++;
         $display("FAIL err_clear: got %b want 0", fifo_err);
      end
      $display("test_check_err: err=%b after reset", fifo_err);
   endtask
`endif

   task automatic test_reset_mid_op();
      cycle(2'b11, 2'b00, 1'b0, 1'b0);
      cycle(2'b11, 2'b01, 1'b0, 1'b1);
      n_checks++;
      if (dut_flags !== 4'b0010 || fifo_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_op: got flags %b err %b want 0010 0", dut_flags, fifo_err);
      end
      cycle(2'b01, 2'b00, 1'b0, 1'b0);
      n_checks++;
      if (uop0 !== q[0] || dut_flags !== 4'b0001) begin
         n_fail++;
         $display("FAIL post_reset_push: got %h flags %b want %h flags 0001", uop0, dut_flags, q[0]);
      end
      $display("test_reset_mid_op: flags=%b uop0=%h", dut_flags, uop0);
   endtask

   initial begin
      rst = 1'b1;
      trap_flush_rvv = 1'b0;
      push = 2'b00;
      pop = 2'b00;
      data_in = '0;
      #1;
      test_reset();
      test_dual_push();
      test_full_boundary();
      test_wrap();
      test_flush();
      test_full_push_pop();
`ifdef RVV_MUL_RS_FIFO_CHECK_EN
      test_check_err();
`endif
      test_reset_mid_op();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
